// File: rtl/ahf_cache_pkg.sv
// Shared definitions for the ahf cache controller: FSM state encoding,
// default geometry and a constant log2 helper.
package ahf_cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WBACK,
        FILL,
        UPDATE
    } cache_state_t;

    localparam int DEF_DATA_W = 14;
    localparam int DEF_ADDR_W = 14;
    localparam int DEF_BLOCKS = 8;
    localparam int DEF_WORDS  = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ahf_cache_tag_cam_v.sv
// Fully associative tag store: per-block tag and valid bit, parallel compare
// against the lookup tag, one-hot match vector and its encoded index.
module ahf_cache_tag_cam_v
    import ahf_cache_pkg::*;
#(
    parameter int BLOCKS = DEF_BLOCKS,
    parameter int TAG_W  = DEF_ADDR_W - clog2(DEF_WORDS),
    parameter int IDX_W  = clog2(BLOCKS)
) (
    input  logic              Clk,
    input  logic              Resetn,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [BLOCKS-1:0] o_match,
    output logic [IDX_W-1:0]  o_idx,
    output logic [BLOCKS-1:0] o_valid,
    output logic [TAG_W-1:0]  o_rd_tag
);

    logic [TAG_W-1:0]  r_tag [BLOCKS];
    logic [BLOCKS-1:0] r_valid;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_valid <= '0;
            for (int i = 0; i < BLOCKS; i++) begin
                r_tag[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_tag[i_wr_idx]   <= i_wr_tag;
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // At most one valid block can carry a given tag, so the encoder needs no priority.
    always_comb begin
        o_match = '0;
        o_idx   = '0;
        for (int i = 0; i < BLOCKS; i++) begin
            o_match[i] = r_valid[i] && (r_tag[i] == i_tag);
            if (o_match[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_rd_tag = r_tag[i_rd_idx];

endmodule

// File: rtl/ahf_cache_ctrl_v.sv
// Fully associative write-back/write-allocate cache controller with a word-level
// memory handshake. Define AHF_CACHE_STATS_EN to add saturating hit/miss counters.
module ahf_cache_ctrl_v
    import ahf_cache_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BLOCKS = DEF_BLOCKS,
    parameter int WORDS  = DEF_WORDS
) (
    input  logic              Clk,
    input  logic              Resetn,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wdata
`ifdef AHF_CACHE_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    localparam int OFF_W = clog2(WORDS);
    localparam int IDX_W = clog2(BLOCKS);
    localparam int TAG_W = ADDR_W - OFF_W;
    localparam int CNT_W = OFF_W + 1;

    cache_state_t      r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_victim;
    logic              r_victim_from_rr;
    logic [IDX_W-1:0]  r_rr;
    logic [BLOCKS-1:0] r_dirty;
    logic [DATA_W-1:0] r_data [BLOCKS*WORDS];

    logic [TAG_W-1:0]  w_tag;
    logic [OFF_W-1:0]  w_off;
    logic [BLOCKS-1:0] w_match;
    logic [IDX_W-1:0]  w_idx;
    logic [BLOCKS-1:0] w_valid;
    logic [TAG_W-1:0]  w_vtag;
    logic              w_hit;
    logic              w_idle;
    logic              w_req;
    logic              w_hit_idle;
    logic              w_fill_issue;
    logic [OFF_W-1:0]  w_cnt_off;
    logic [OFF_W-1:0]  w_fill_off;
    logic [IDX_W-1:0]  w_victim;
    logic              w_victim_from_rr;

    assign w_tag        = cpu_addr[ADDR_W-1:OFF_W];
    assign w_off        = cpu_addr[OFF_W-1:0];
    assign w_hit        = |w_match;
    assign w_idle       = (r_state == IDLE);
    assign w_req        = cpu_rd | cpu_wr;
    assign w_hit_idle   = w_idle & w_hit;
    assign w_cnt_off    = r_cnt[OFF_W-1:0];
    assign w_fill_off   = w_cnt_off - OFF_W'(1);
    assign w_fill_issue = (r_state == FILL) && !r_cnt[OFF_W];

    ahf_cache_tag_cam_v #(
        .BLOCKS (BLOCKS),
        .TAG_W  (TAG_W),
        .IDX_W  (IDX_W)
    ) u_tag_cam (
        .Clk      (Clk),
        .Resetn   (Resetn),
        .i_tag    (w_tag),
        .i_wr_en  (r_state == UPDATE),
        .i_wr_idx (r_victim),
        .i_wr_tag (w_tag),
        .i_rd_idx (r_victim),
        .o_match  (w_match),
        .o_idx    (w_idx),
        .o_valid  (w_valid),
        .o_rd_tag (w_vtag)
    );

    // Descending scan so the lowest-index invalid block wins; rr only when all are valid.
    always_comb begin
        w_victim         = r_rr;
        w_victim_from_rr = 1'b1;
        for (int i = BLOCKS - 1; i >= 0; i--) begin
            if (!w_valid[i]) begin
                w_victim         = IDX_W'(i);
                w_victim_from_rr = 1'b0;
            end
        end
    end

    assign cpu_rdata = w_hit_idle ? r_data[{w_idx, w_off}] : '0;
    assign stall     = !w_idle || (w_req && !w_hit);
    assign mem_wren  = (r_state == WBACK);
    assign mem_rden  = w_fill_issue;
    assign mem_wdata = (r_state == WBACK) ? r_data[{r_victim, w_cnt_off}] : '0;

    always_comb begin
        mem_addr = '0;
        if (r_state == WBACK) begin
            mem_addr = {w_vtag, w_cnt_off};
        end else if (w_fill_issue) begin
            mem_addr = {w_tag, w_cnt_off};
        end
    end

    // Each fill word lands one cycle after its read strobe, hence the cnt-1 slot.
    always_ff @(posedge Clk) begin
        if (w_hit_idle && cpu_wr) begin
            r_data[{w_idx, w_off}] <= cpu_wdata;
        end else if ((r_state == FILL) && (r_cnt != '0)) begin
            r_data[{r_victim, w_fill_off}] <= mem_rdata;
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_state          <= IDLE;
            r_cnt            <= '0;
            r_victim         <= '0;
            r_victim_from_rr <= 1'b0;
            r_rr             <= '0;
            r_dirty          <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req && !w_hit) begin
                        r_victim         <= w_victim;
                        r_victim_from_rr <= w_victim_from_rr;
                        r_cnt            <= '0;
                        r_state          <= (w_valid[w_victim] && r_dirty[w_victim]) ? WBACK : FILL;
                    end else if (w_hit && cpu_wr) begin
                        r_dirty[w_idx] <= 1'b1;
                    end
                end
                WBACK: begin
                    if (r_cnt == CNT_W'(WORDS - 1)) begin
                        r_cnt             <= '0;
                        r_dirty[r_victim] <= 1'b0;
                        r_state           <= FILL;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                FILL: begin
                    if (r_cnt == CNT_W'(WORDS)) begin
                        r_cnt   <= '0;
                        r_state <= UPDATE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                UPDATE: begin
                    r_dirty[r_victim] <= 1'b0;
                    if (r_victim_from_rr) begin
                        r_rr <= r_rr + IDX_W'(1);
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef AHF_CACHE_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit_idle && w_req && (r_hit_count != 16'hFFFF)) begin
                r_hit_count <= r_hit_count + 16'd1;
            end
            if (w_idle && w_req && !w_hit && (r_miss_count != 16'hFFFF)) begin
                r_miss_count <= r_miss_count + 16'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_ahf_cache_ctrl_v.sv
// Directed testbench for ahf_cache_ctrl_v: backing-memory model, read-data
// scoreboard and per-access stall/strobe bookkeeping.
module tb_ahf_cache_ctrl_v;

    logic        clk = 1'b0;
    logic        Resetn;
    logic [13:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [13:0] cpu_wdata;
    logic [13:0] cpu_rdata;
    logic        stall;
    logic [13:0] mem_addr;
    logic        mem_rden;
    logic [13:0] mem_rdata = '0;
    logic        mem_wren;
    logic [13:0] mem_wdata;
`ifdef AHF_CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int checks   = 0;
    int failures = 0;

    int          stallCyc;
    int          wrCnt;
    int          rdCnt;
    int          bothCnt;
    int          wbBad;
    logic        timedOut;
    logic        found;
    logic [13:0] firstWr;
    logic [13:0] lastWr;
    logic [13:0] firstRd;
    logic [13:0] lastRd;

    logic [13:0] expQ [$];
    logic [13:0] gm [int];

    bit [13:0] memArr [16384];
    bit        memWritten [16384];

    ahf_cache_ctrl_v dut (
        .Clk        (clk),
        .Resetn     (Resetn),
        .cpu_addr   (cpu_addr),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .stall      (stall),
        .mem_addr   (mem_addr),
        .mem_rden   (mem_rden),
        .mem_rdata  (mem_rdata),
        .mem_wren   (mem_wren),
        .mem_wdata  (mem_wdata)
`ifdef AHF_CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] initVal(input logic [13:0] a);
        if (a == 14'h0005) return 14'h1234;
        return a * 14'd3 + 14'h0101;
    endfunction

    function automatic logic [13:0] memRead(input logic [13:0] a);
        return memWritten[a] ? memArr[a] : initVal(a);
    endfunction

    function automatic logic [13:0] expVal(input logic [13:0] a);
        return gm.exists(int'(a)) ? gm[int'(a)] : initVal(a);
    endfunction

    // Backing RAM: write at the strobe edge, read data appears one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_wren) begin
            memArr[mem_addr]     <= mem_wdata;
            memWritten[mem_addr] <= 1'b1;
        end
        if (mem_rden) begin
            mem_rdata <= memRead(mem_addr);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One CPU access: hold the request until stall drops, logging memory strobes on the way.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [13:0] addr, input logic [13:0] wd);
        logic [13:0] expv;
        stallCyc = 0; wrCnt = 0; rdCnt = 0; bothCnt = 0; wbBad = 0;
        firstWr = '1; lastWr = '1; firstRd = '1; lastRd = '1;
        cpu_addr  = addr;
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_wdata = wd;
        if (rd) expQ.push_back(expVal(addr));
        if (wr) gm[int'(addr)] = wd;
        timedOut = 1'b1;
        for (int guard = 0; guard < 200; guard++) begin
            @(negedge clk);
            if (mem_wren) begin
                if (wrCnt == 0) firstWr = mem_addr;
                lastWr = mem_addr;
                wrCnt++;
                if (mem_wdata !== expVal(mem_addr)) wbBad++;
            end
            if (mem_rden) begin
                if (rdCnt == 0) firstRd = mem_addr;
                lastRd = mem_addr;
                rdCnt++;
            end
            if (mem_wren && mem_rden) bothCnt++;
            if (!stall) begin
                timedOut = 1'b0;
                break;
            end
            stallCyc++;
            @(posedge clk);
        end
        if (rd && (expQ.size() > 0)) begin
            expv = expQ.pop_front();
            if (!timedOut) checkOutput($sformatf("cpu_rdata@%0h", addr), 32'(cpu_rdata), 32'(expv));
        end
        if (timedOut) checkOutput("stall_timeout", 32'(timedOut), 32'd0);
        @(posedge clk);
        #1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    initial begin
        Resetn    = 1'b0;
        cpu_addr  = '0;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        checkOutput("rst_mem_rden", 32'(mem_rden), 32'd0);
        checkOutput("rst_mem_wren", 32'(mem_wren), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
`ifdef AHF_CACHE_STATS_EN
        checkOutput("rst_hit_count", 32'(hit_count), 32'd0);
        checkOutput("rst_miss_count", 32'(miss_count), 32'd0);
`endif
        @(posedge clk);
        #1;
        Resetn = 1'b1;

        $display("[TB] clean miss on 0x0005");
        applyStimulus(1'b1, 1'b0, 14'h0005, 14'h0);
        checkOutput("miss1_stall", 32'(stallCyc), 32'd19);
        checkOutput("miss1_rden_cnt", 32'(rdCnt), 32'd16);
        checkOutput("miss1_first_rd", 32'(firstRd), 32'h0000);
        checkOutput("miss1_last_rd", 32'(lastRd), 32'h000F);
        checkOutput("miss1_wren_cnt", 32'(wrCnt), 32'd0);

        $display("[TB] write hit and read back");
        applyStimulus(1'b0, 1'b1, 14'h0005, 14'h0ABC);
        checkOutput("wrhit_stall", 32'(stallCyc), 32'd0);
        applyStimulus(1'b1, 1'b0, 14'h0005, 14'h0);
        checkOutput("rdhit_stall", 32'(stallCyc), 32'd0);
        checkOutput("rdhit_wren_cnt", 32'(wrCnt), 32'd0);

        $display("[TB] simultaneous read and write");
        applyStimulus(1'b1, 1'b1, 14'h0006, 14'h0155);
        checkOutput("rdwr_stall", 32'(stallCyc), 32'd0);
        applyStimulus(1'b1, 1'b0, 14'h0006, 14'h0);

        $display("[TB] fill blocks 1..7");
        for (int t = 1; t < 8; t++) begin
            applyStimulus(1'b1, 1'b0, 14'(t * 16 + 3), 14'h0);
            checkOutput($sformatf("fill_tag%0d_stall", t), 32'(stallCyc), 32'd19);
        end

        $display("[TB] dirty eviction of block 0");
        applyStimulus(1'b1, 1'b0, 14'h0085, 14'h0);
        checkOutput("dirty_stall", 32'(stallCyc), 32'd35);
        checkOutput("dirty_wren_cnt", 32'(wrCnt), 32'd16);
        checkOutput("dirty_first_wr", 32'(firstWr), 32'h0000);
        checkOutput("dirty_last_wr", 32'(lastWr), 32'h000F);
        checkOutput("dirty_wb_data_errs", 32'(wbBad), 32'd0);
        checkOutput("dirty_rden_cnt", 32'(rdCnt), 32'd16);
        checkOutput("dirty_first_rd", 32'(firstRd), 32'h0080);
        checkOutput("dirty_both_strobes", 32'(bothCnt), 32'd0);

        $display("[TB] round-robin victim order");
        applyStimulus(1'b1, 1'b0, 14'h0091, 14'h0);
        checkOutput("rr_tag9_stall", 32'(stallCyc), 32'd19);
        checkOutput("rr_tag9_wren_cnt", 32'(wrCnt), 32'd0);
        applyStimulus(1'b1, 1'b0, 14'h0080, 14'h0);
        checkOutput("rr_tag8_hit", 32'(stallCyc), 32'd0);
        applyStimulus(1'b1, 1'b0, 14'h0025, 14'h0);
        checkOutput("rr_tag2_hit", 32'(stallCyc), 32'd0);
        applyStimulus(1'b1, 1'b0, 14'h0015, 14'h0);
        checkOutput("rr_tag1_miss", 32'(stallCyc), 32'd19);
        applyStimulus(1'b1, 1'b0, 14'h0005, 14'h0);
        checkOutput("refetch_wb_stall", 32'(stallCyc), 32'd19);

        $display("[TB] reset during fill");
        cpu_addr = 14'h0305;
        cpu_rd   = 1'b1;
        found    = 1'b0;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (mem_rden && (mem_addr == 14'h0307)) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("fill7_reached", 32'(found), 32'd1);
        cpu_rd = 1'b0;
        Resetn = 1'b0;
        #1;
        checkOutput("midrst_stall", 32'(stall), 32'd0);
        checkOutput("midrst_mem_rden", 32'(mem_rden), 32'd0);
        checkOutput("midrst_mem_wren", 32'(mem_wren), 32'd0);
        checkOutput("midrst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("midrst_mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("midrst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        @(posedge clk);
        #1;
        Resetn = 1'b1;
        applyStimulus(1'b1, 1'b0, 14'h0305, 14'h0);
        checkOutput("refill_stall", 32'(stallCyc), 32'd19);
        checkOutput("refill_rden_cnt", 32'(rdCnt), 32'd16);
        applyStimulus(1'b1, 1'b0, 14'h0306, 14'h0);
        checkOutput("post_hit1_stall", 32'(stallCyc), 32'd0);
        applyStimulus(1'b1, 1'b0, 14'h0307, 14'h0);
        checkOutput("post_hit2_stall", 32'(stallCyc), 32'd0);
`ifdef AHF_CACHE_STATS_EN
        checkOutput("stats_miss_count", 32'(miss_count), 32'd1);
        checkOutput("stats_hit_count", 32'(hit_count), 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
